// File: rtl/mfp_eic_sense_pkg.sv
// Shared definitions for the EIC input-conditioning stage: sense codes,
// word geometry and an index-width helper.
package mfp_eic_sense_pkg;

  typedef enum logic [1:0] {
    SENSE_OFF   = 2'b00,
    SENSE_RISE  = 2'b01,
    SENSE_FALL  = 2'b10,
    SENSE_LEVEL = 2'b11
  } sense_e;

  localparam int unsigned SENSE_WORD_CH = 16;
  localparam int unsigned CLEAR_WORD_CH = 32;

  // A single word still needs a one-bit index port.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 32'd1) ? $clog2(words) : 32'd1;
  endfunction

endpackage

// File: rtl/mfp_eic_sense_channel.sv
// One interrupt line: synchroniser, optional glitch filter, edge detect and
// sticky pending bit governed by the channel's sense code.
module mfp_eic_sense_channel
  import mfp_eic_sense_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 0
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   signal_i,
  input  sense_e sense_i,
  input  logic   clr_i,
  output logic   pending_o,
  output logic   level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_s;
  logic                   level_s;
  logic                   prev_q;
  logic                   pending_q;
  logic                   pending_d;
  logic                   rise_s;
  logic                   fall_s;

  // Synchroniser chain, shifts towards the MSB.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
    end
  end

  assign s_s = sync_q[SYNC_STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_bypass
    assign level_s = s_s;
  end else begin : g_filter
    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          lvl_q;

    // Level only follows s after N consecutive differing cycles.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (s_s == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        lvl_q <= s_s;
        cnt_q <= '0;
      end else if (cnt_q != {CW{1'b1}}) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end

    assign level_s = lvl_q;
  end

  // Pending next state; prev is tracked in every mode so enabling edge
  // sense on an already-high line does not fire.
  always_comb begin
    rise_s    = level_s & ~prev_q;
    fall_s    = ~level_s & prev_q;
    pending_d = 1'b0;
    case (sense_i)
      SENSE_OFF:   pending_d = 1'b0;
      SENSE_RISE:  pending_d = (pending_q & ~clr_i) | rise_s;
      SENSE_FALL:  pending_d = (pending_q & ~clr_i) | fall_s;
      SENSE_LEVEL: pending_d = level_s;
      default:     pending_d = 1'b0;
    endcase
  end

  // Previous level and pending state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= level_s;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign level_o   = level_s;

endmodule

// File: rtl/mfp_eic_sense.sv
// EIC input conditioning: per-channel sense pipeline plus the sense-config
// register file and write-1-to-clear decode shared across channels.
module mfp_eic_sense
  import mfp_eic_sense_pkg::*;
#(
  parameter  int unsigned CHANNELS      = 32,
  parameter  int unsigned SYNC_STAGES   = 2,
  parameter  int unsigned FILTER_CYCLES = 0,
  localparam int unsigned SENSE_WORDS   = CHANNELS / SENSE_WORD_CH,
  localparam int unsigned CLEAR_WORDS   = (CHANNELS + CLEAR_WORD_CH - 1) / CLEAR_WORD_CH,
  localparam int unsigned SIDX_W        = idx_width(SENSE_WORDS),
  localparam int unsigned CIDX_W        = idx_width(CLEAR_WORDS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] signal,
  input  logic                sense_we,
  input  logic [SIDX_W-1:0]   sense_idx,
  input  logic [31:0]         sense_wdata,
  output logic [31:0]         sense_rdata,
  input  logic                clear_we,
  input  logic [CIDX_W-1:0]   clear_idx,
  input  logic [31:0]         clear_data,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] level
);

  logic [31:0]         sense_q [SENSE_WORDS];
  logic                sidx_ok_s;
  logic [CHANNELS-1:0] clr_s;

  assign sidx_ok_s = (32'(sense_idx) < SENSE_WORDS);

  // Sense configuration words; out-of-range indices are dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int w = 0; w < int'(SENSE_WORDS); w++) begin
        sense_q[w] <= 32'h0000_0000;
      end
    end else if (sense_we && sidx_ok_s) begin
      sense_q[sense_idx] <= sense_wdata;
    end
  end

  // Read-back of the addressed sense word.
  always_comb begin
    if (sidx_ok_s) begin
      sense_rdata = sense_q[sense_idx];
    end else begin
      sense_rdata = 32'h0000_0000;
    end
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    assign clr_s[i] = clear_we && (clear_idx == CIDX_W'(i / 32)) && clear_data[i % 32];

    mfp_eic_sense_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_channel (
      .CLK      (CLK),
      .RESET    (RESET),
      .signal_i (signal[i]),
      .sense_i  (sense_e'(sense_q[i / 16][2 * (i % 16) +: 2])),
      .clr_i    (clr_s[i]),
      .pending_o(pending[i]),
      .level_o  (level[i])
    );
  end

endmodule

// File: tb/tb_mfp_eic_sense.sv
// Scoreboard bench for mfp_eic_sense: one unfiltered instance and one with a
// 4-cycle glitch filter, sharing configuration and clear ports.
module tb_mfp_eic_sense;

  localparam int SEL_PA = 0;
  localparam int SEL_LA = 1;
  localparam int SEL_PB = 2;
  localparam int SEL_LB = 3;

  logic        clk;
  logic        rst;
  logic [31:0] sig_a;
  logic [31:0] sig_b;
  logic        sense_we;
  logic        sense_idx;
  logic [31:0] sense_wdata;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        clear_we;
  logic        clear_idx;
  logic [31:0] clear_data;
  logic [31:0] pend_a;
  logic [31:0] pend_b;
  logic [31:0] lvl_a;
  logic [31:0] lvl_b;

  int cyc     = 0;
  int n_check = 0;
  int n_pass  = 0;

  typedef struct {
    string       tag;
    int          due;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];

  mfp_eic_sense #(.CHANNELS(32), .SYNC_STAGES(2), .FILTER_CYCLES(0)) u_dut_a (
    .CLK(clk), .RESET(rst), .signal(sig_a),
    .sense_we(sense_we), .sense_idx(sense_idx), .sense_wdata(sense_wdata),
    .sense_rdata(rdata_a),
    .clear_we(clear_we), .clear_idx(clear_idx), .clear_data(clear_data),
    .pending(pend_a), .level(lvl_a)
  );

  mfp_eic_sense #(.CHANNELS(32), .SYNC_STAGES(2), .FILTER_CYCLES(4)) u_dut_b (
    .CLK(clk), .RESET(rst), .signal(sig_b),
    .sense_we(sense_we), .sense_idx(sense_idx), .sense_wdata(sense_wdata),
    .sense_rdata(rdata_b),
    .clear_we(clear_we), .clear_idx(clear_idx), .clear_data(clear_data),
    .pending(pend_b), .level(lvl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sel_obs(input int sel);
    case (sel)
      SEL_PA:  return pend_a;
      SEL_LA:  return lvl_a;
      SEL_PB:  return pend_b;
      SEL_LB:  return lvl_b;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Compare every expectation that falls due at this negedge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_eq(sb[i].tag, sel_obs(sb[i].sel) & sb[i].mask, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input string tag, input int dly, input int sel,
                           input logic [31:0] mask, input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.due  = cyc + dly;
    e.sel  = sel;
    e.mask = mask;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr_sense(input logic idx, input logic [31:0] data);
    sense_we    = 1'b1;
    sense_idx   = idx;
    sense_wdata = data;
    step();
    sense_we    = 1'b0;
  endtask

  task automatic wr_clear(input logic [31:0] data);
    clear_we   = 1'b1;
    clear_idx  = 1'b0;
    clear_data = data;
    step();
    clear_we   = 1'b0;
    clear_data = 32'h0;
  endtask

  initial begin
    rst         = 1'b1;
    sig_a       = 32'h0;
    sig_b       = 32'h0;
    sense_we    = 1'b0;
    sense_idx   = 1'b0;
    sense_wdata = 32'h0;
    clear_we    = 1'b0;
    clear_idx   = 1'b0;
    clear_data  = 32'h0;
    step();
    step();
    check_eq("rst_pend", pend_a, 32'h0);
    check_eq("rst_level", lvl_a, 32'h0);
    check_eq("rst_rdata", rdata_a, 32'h0);
    rst      = 1'b0;
    sig_b[1] = 1'b1;

    // 1: async reset while ch0 (rise) and ch2 (level) are pending
    wr_sense(1'b0, 32'h0000_0031);
    sig_a[0] = 1'b1;
    sig_a[2] = 1'b1;
    expect_at("t1_pend_early", 2, SEL_PA, 32'h5, 32'h0);
    expect_at("t1_pend_set", 3, SEL_PA, 32'h5, 32'h5);
    repeat (4) step();
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("t1_async_pend", pend_a, 32'h0);
    check_eq("t1_async_level", lvl_a, 32'h0);
    sig_a = 32'h0;
    step();
    step();
    rst = 1'b0;
    check_eq("t1_rdata_rst", rdata_a, 32'h0);
    for (int d = 1; d <= 4; d++) expect_at("t1_after_release", d, SEL_PA, 32'hFFFF_FFFF, 32'h0);
    repeat (5) step();

    // 2: ch0 rising edge, unfiltered
    wr_sense(1'b0, 32'h0000_0001);
    sig_a[0] = 1'b1;
    expect_at("t2_level_early", 1, SEL_LA, 32'h1, 32'h0);
    expect_at("t2_level", 2, SEL_LA, 32'h1, 32'h1);
    expect_at("t2_pend_early", 2, SEL_PA, 32'h1, 32'h0);
    expect_at("t2_pend_set", 3, SEL_PA, 32'h1, 32'h1);
    repeat (4) step();
    expect_at("t2_cleared", 1, SEL_PA, 32'h1, 32'h0);
    expect_at("t2_stays_clear", 3, SEL_PA, 32'h1, 32'h0);
    wr_clear(32'h1);
    sig_a[0] = 1'b0;
    expect_at("t2_fall_no_set", 3, SEL_PA, 32'h1, 32'h0);
    expect_at("t2_fall_no_set2", 5, SEL_PA, 32'h1, 32'h0);
    repeat (6) step();

    // 3: ch1 falling edge through the 4-cycle filter
    wr_sense(1'b0, 32'h0000_0009);
    expect_at("t3_level_high", 1, SEL_LB, 32'h2, 32'h2);
    sig_b[1] = 1'b0;
    for (int d = 1; d <= 10; d++) expect_at("t3_glitch_pend", d, SEL_PB, 32'h2, 32'h0);
    for (int d = 2; d <= 8; d++) expect_at("t3_glitch_level", d, SEL_LB, 32'h2, 32'h2);
    repeat (3) step();
    sig_b[1] = 1'b1;
    repeat (10) step();
    sig_b[1] = 1'b0;
    expect_at("t3_level_hold", 5, SEL_LB, 32'h2, 32'h2);
    expect_at("t3_level_fall", 6, SEL_LB, 32'h2, 32'h0);
    expect_at("t3_pend_early", 6, SEL_PB, 32'h2, 32'h0);
    expect_at("t3_pend_set", 7, SEL_PB, 32'h2, 32'h2);
    repeat (6) step();
    sig_b[1] = 1'b1;
    repeat (8) step();

    // 4: ch2 high-level sense ignores clear while high
    wr_sense(1'b0, 32'h0000_0039);
    sig_a[2] = 1'b1;
    expect_at("t4_pend_early", 2, SEL_PA, 32'h4, 32'h0);
    expect_at("t4_pend_set", 3, SEL_PA, 32'h4, 32'h4);
    repeat (4) step();
    expect_at("t4_clr_ignored", 1, SEL_PA, 32'h4, 32'h4);
    expect_at("t4_clr_ignored2", 2, SEL_PA, 32'h4, 32'h4);
    wr_clear(32'h4);
    step();
    sig_a[2] = 1'b0;
    expect_at("t4_pend_hold", 2, SEL_PA, 32'h4, 32'h4);
    expect_at("t4_pend_drop", 3, SEL_PA, 32'h4, 32'h0);
    repeat (4) step();

    // 5: ch3 rise event and clear on the same edge
    wr_sense(1'b0, 32'h0000_0079);
    sig_a[3] = 1'b1;
    expect_at("t5_set_wins", 3, SEL_PA, 32'h8, 32'h8);
    expect_at("t5_set_holds", 4, SEL_PA, 32'h8, 32'h8);
    step();
    step();
    wr_clear(32'h8);
    repeat (3) step();

    // 6: enabling edge sense on an already-high line, then disabling it
    sig_a[4] = 1'b1;
    repeat (5) step();
    wr_sense(1'b0, 32'h0000_0179);
    for (int d = 1; d <= 4; d++) expect_at("t6_no_event", d, SEL_PA, 32'h10, 32'h0);
    repeat (5) step();
    check_eq("t6_rdata_w0", rdata_a, 32'h0000_0179);
    wr_sense(1'b1, 32'hA5A5_0000);
    check_eq("t6_rdata_w1", rdata_a, 32'hA5A5_0000);
    sense_idx = 1'b0;
    #1;
    check_eq("t6_rdata_w0_again", rdata_a, 32'h0000_0179);
    sig_a[4] = 1'b0;
    repeat (3) step();
    sig_a[4] = 1'b1;
    expect_at("t6_pend_set", 3, SEL_PA, 32'h10, 32'h10);
    repeat (4) step();
    expect_at("t6_pend_before_off", 1, SEL_PA, 32'h10, 32'h10);
    expect_at("t6_pend_off", 2, SEL_PA, 32'h10, 32'h0);
    wr_sense(1'b0, 32'h0000_0079);
    repeat (3) step();
    check_eq("final_level", lvl_a, sig_a);

    for (int n = 0; n < 100 && sb.size() != 0; n++) step();
    if (sb.size() != 0) check_eq("sb_drain", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
